// File: rtl/change_dispenser_pkg.sv
// Shared vending definitions: dispenser FSM state type and coin-unit constants.
// All amounts are expressed in small-coin units.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHOOSE,
    PULSE,
    GAP,
    FINISH
  } disp_state_t;

  // Coin values in small-coin units, shared with the beverage controller.
  localparam int unsigned SMALL_COIN_UNITS = 1;
  localparam int unsigned BIG_COIN_UNITS   = 2;

endpackage

// File: rtl/change_dispenser_if.sv
// Controller <-> change dispenser connection.
//  start/amount/refill : payout request and stock reload (controller drives)
//  busy/done/short_err : payout status
//  eject_big/small     : hopper solenoid pulses
//  remaining           : units still unpaid
//  stock_big/small     : coins left in each hopper
interface change_dispenser_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned SW = 6
) ();

  logic          start;
  logic [AW-1:0] amount;
  logic          refill;
  logic          busy;
  logic          eject_big;
  logic          eject_small;
  logic          done;
  logic          short_err;
  logic [AW-1:0] remaining;
  logic [SW-1:0] stock_big;
  logic [SW-1:0] stock_small;

  modport master (
    output start, amount, refill,
    input  busy, eject_big, eject_small, done, short_err, remaining, stock_big, stock_small
  );

  modport slave (
    input  start, amount, refill,
    output busy, eject_big, eject_small, done, short_err, remaining, stock_big, stock_small
  );

endinterface

// File: rtl/change_dispenser_pulse_timer.sv
// Down-counter timing eject pulses and inter-pulse gaps.
//  clk, reset : clock, synchronous active-low reset
//  load       : load load_val into the counter
//  load_val   : cycles-1 of the interval being timed
//  expired    : counter has reached zero
module pulse_timer #(
  parameter int unsigned TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount out as timed eject pulses to a big and a
// small coin hopper, big coins first, tracking hopper stock and flagging a
// shortfall (unpaid amount left in remaining).
//  clk, reset : clock, synchronous active-low reset
//  bus        : slave side of change_dispenser_if (request in, status/ejects out)
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned AW         = 4,
  parameter int unsigned SW         = 6,
  parameter int unsigned BIG_VAL    = BIG_COIN_UNITS,
  parameter int unsigned INIT_BIG   = 10,
  parameter int unsigned INIT_SMALL = 10,
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned GAP_CYC    = 2
) (
  input logic                clk,
  input logic                reset,
  change_dispenser_if.slave  bus
);

  localparam int unsigned MaxCyc = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  disp_state_t   state_q, state_d;
  logic          busy_q, busy_d;
  logic          eject_big_q, eject_big_d;
  logic          eject_small_q, eject_small_d;
  logic          done_q, done_d;
  logic          short_q, short_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [SW-1:0] stock_big_q, stock_big_d;
  logic [SW-1:0] stock_small_q, stock_small_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expired;
  logic          choose;

  pulse_timer #(
    .TW (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    eject_big_d   = eject_big_q;
    eject_small_d = eject_small_q;
    done_d        = 1'b0;
    short_d       = short_q;
    rem_d         = rem_q;
    stock_big_d   = stock_big_q;
    stock_small_d = stock_small_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    choose        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Refill lands in the same edge as start, so CHOOSE sees the new stock.
        if (bus.refill) begin
          stock_big_d   = SW'(INIT_BIG);
          stock_small_d = SW'(INIT_SMALL);
        end
        if (bus.start) begin
          state_d = CHOOSE;
          busy_d  = 1'b1;
          rem_d   = bus.amount;
          short_d = 1'b0;
        end
      end
      CHOOSE: choose = 1'b1;
      PULSE: begin
        if (tmr_expired) begin
          state_d       = GAP;
          eject_big_d   = 1'b0;
          eject_small_d = 1'b0;
          tmr_load      = 1'b1;
          tmr_val       = TW'(GAP_CYC - 1);
        end
      end
      // The choice is made on the last gap cycle so the low gap between
      // pulses is exactly GAP_CYC cycles.
      GAP:    choose  = tmr_expired;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (choose) begin
      if (rem_q == '0) begin
        state_d = FINISH;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else if (rem_q >= AW'(BIG_VAL) && stock_big_q != '0) begin
        state_d     = PULSE;
        eject_big_d = 1'b1;
        rem_d       = rem_q - AW'(BIG_VAL);
        stock_big_d = stock_big_q - 1'b1;
        tmr_load    = 1'b1;
        tmr_val     = TW'(PULSE_CYC - 1);
      end else if (stock_small_q != '0) begin
        state_d       = PULSE;
        eject_small_d = 1'b1;
        rem_d         = rem_q - AW'(SMALL_COIN_UNITS);
        stock_small_d = stock_small_q - 1'b1;
        tmr_load      = 1'b1;
        tmr_val       = TW'(PULSE_CYC - 1);
      end else begin
        state_d = FINISH;
        short_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      eject_big_q   <= 1'b0;
      eject_small_q <= 1'b0;
      done_q        <= 1'b0;
      short_q       <= 1'b0;
      rem_q         <= '0;
      stock_big_q   <= SW'(INIT_BIG);
      stock_small_q <= SW'(INIT_SMALL);
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      eject_big_q   <= eject_big_d;
      eject_small_q <= eject_small_d;
      done_q        <= done_d;
      short_q       <= short_d;
      rem_q         <= rem_d;
      stock_big_q   <= stock_big_d;
      stock_small_q <= stock_small_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.eject_big   = eject_big_q;
  assign bus.eject_small = eject_small_q;
  assign bus.done        = done_q;
  assign bus.short_err   = short_q;
  assign bus.remaining   = rem_q;
  assign bus.stock_big   = stock_big_q;
  assign bus.stock_small = stock_small_q;

endmodule
